// File: rtl/ifid_buffer.sv
// ifid_buffer: 2-entry FIFO of {PC, Instr} pairs between fetch and decode.
//
// Ports
//   clk        rising-edge clock
//   rst        asynchronous active-low reset
//   PCresult   fetch address (PC_W)
//   Instr      fetched instruction word (INSTR_W)
//   FetchValid PCresult/Instr valid this cycle
//   IDReady    decode accepts the head entry this cycle
//   Flush      synchronous discard of all buffered fetches
//   PCWrt      1 = buffer can accept (PC write enable), registered-state only
//   IDInstr    head instruction, 0 when empty
//   IDPC       head address, 0 when empty
//   IDPCPlus4  IDPC + 4 modulo 2^PC_W
//   IDValid    head entry valid
//   Count      occupied entries, 0..2
//   StallCnt   (only with IFID_STALL_COUNT_EN) saturating count of cycles
//              in which a fetch was refused because the buffer was full
//
// Optional feature macro: IFID_STALL_COUNT_EN
module ifid_buffer #(
  parameter int PC_W    = 8,
  parameter int INSTR_W = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [PC_W-1:0]    PCresult,
  input  logic [INSTR_W-1:0] Instr,
  input  logic               FetchValid,
  input  logic               IDReady,
  input  logic               Flush,
  output logic               PCWrt,
  output logic [INSTR_W-1:0] IDInstr,
  output logic [PC_W-1:0]    IDPC,
  output logic [PC_W-1:0]    IDPCPlus4,
  output logic               IDValid,
`ifdef IFID_STALL_COUNT_EN
  output logic [7:0]         StallCnt,
`endif
  output logic [1:0]         Count
);

  logic [1:0][PC_W-1:0]    pc_q;
  logic [1:0][INSTR_W-1:0] instr_q;
  logic                    wr_ptr_q, rd_ptr_q;
  logic [1:0]              cnt_q, cnt_d;
  logic                    push, pop;

  // Status is decoded from the registered count only, so PCWrt has no
  // combinational path from any input.
  assign PCWrt   = (cnt_q != 2'd2);
  assign IDValid = (cnt_q != 2'd0);
  assign Count   = cnt_q;

  assign push = FetchValid && PCWrt;
  assign pop  = IDValid && IDReady;

  // Empty buffer presents a NOP at address 0.
  assign IDInstr   = IDValid ? instr_q[rd_ptr_q] : '0;
  assign IDPC      = IDValid ? pc_q[rd_ptr_q]    : '0;
  assign IDPCPlus4 = IDPC + PC_W'(4);

  always_comb begin
    cnt_d = cnt_q;
    case ({push, pop})
      2'b10:   cnt_d = cnt_q + 2'd1;
      2'b01:   cnt_d = cnt_q - 2'd1;
      default: cnt_d = cnt_q;
    endcase
    if (Flush) cnt_d = 2'd0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc_q     <= '0;
      instr_q  <= '0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      cnt_q    <= 2'd0;
    end else begin
      cnt_q <= cnt_d;
      if (Flush) begin
        // Flush wins over a same-cycle push/pop; storage contents are
        // don't-care once the count is zero.
        wr_ptr_q <= 1'b0;
        rd_ptr_q <= 1'b0;
      end else begin
        if (push) begin
          pc_q[wr_ptr_q]    <= PCresult;
          instr_q[wr_ptr_q] <= Instr;
          wr_ptr_q          <= ~wr_ptr_q;
        end
        if (pop) rd_ptr_q <= ~rd_ptr_q;
      end
    end
  end

`ifdef IFID_STALL_COUNT_EN
  logic [7:0] stall_q;
  assign StallCnt = stall_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                                           stall_q <= 8'h00;
    else if (Flush)                                     stall_q <= 8'h00;
    else if (FetchValid && !PCWrt && stall_q != 8'hFF)  stall_q <= stall_q + 8'h01;
  end
`endif

endmodule

// File: tb/tb_ifid_buffer.sv
module tb_ifid_buffer;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  PCresult;
  logic [31:0] Instr;
  logic        FetchValid, IDReady, Flush;
  logic        PCWrt, IDValid;
  logic [31:0] IDInstr;
  logic [7:0]  IDPC, IDPCPlus4;
  logic [1:0]  Count;
`ifdef IFID_STALL_COUNT_EN
  logic [7:0]  StallCnt;
`endif

  always #5 clk = ~clk;

  ifid_buffer #(.PC_W(8), .INSTR_W(32)) dut (
    .clk(clk), .rst(rst), .PCresult(PCresult), .Instr(Instr),
    .FetchValid(FetchValid), .IDReady(IDReady), .Flush(Flush),
    .PCWrt(PCWrt), .IDInstr(IDInstr), .IDPC(IDPC), .IDPCPlus4(IDPCPlus4),
    .IDValid(IDValid),
`ifdef IFID_STALL_COUNT_EN
    .StallCnt(StallCnt),
`endif
    .Count(Count)
  );

  typedef struct packed {
    logic [7:0]  pc;
    logic [31:0] ins;
  } ent_t;

  ent_t sb[$];
  int   total = 0;
  int   bad   = 0;
  int   stall_m = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Compare every visible output against the scoreboard head/occupancy.
  task automatic check_outs();
    logic [7:0] p4;
    chk("count",   64'(Count),   64'(sb.size()));
    chk("pcwrt",   64'(PCWrt),   64'(sb.size() != 2));
    chk("idvalid", 64'(IDValid), 64'(sb.size() != 0));
    if (sb.size() != 0) begin
      p4 = sb[0].pc + 8'd4;
      chk("idpc",    64'(IDPC),      64'(sb[0].pc));
      chk("idinstr", 64'(IDInstr),   64'(sb[0].ins));
      chk("plus4",   64'(IDPCPlus4), 64'(p4));
    end else begin
      chk("idpc0",    64'(IDPC),      64'd0);
      chk("idinstr0", 64'(IDInstr),   64'd0);
      chk("plus4_0",  64'(IDPCPlus4), 64'h04);
    end
`ifdef IFID_STALL_COUNT_EN
    chk("stallcnt", 64'(StallCnt), 64'(stall_m));
`endif
  endtask

  // Drive one cycle of stimulus, check current outputs, then advance the model.
  task automatic step(input logic fv, input logic [7:0] pc, input logic [31:0] ins,
                      input logic rdy, input logic fl);
    int   n;
    ent_t e;
    @(negedge clk);
    FetchValid = fv; PCresult = pc; Instr = ins; IDReady = rdy; Flush = fl;
    #1 check_outs();
    n = sb.size();
    if (fl) begin
      sb.delete();
      stall_m = 0;
    end else begin
      if (fv && n == 2 && stall_m < 255) stall_m++;
      if (n > 0 && rdy) void'(sb.pop_front());
      if (fv && n < 2) begin
        e.pc = pc; e.ins = ins;
        sb.push_back(e);
      end
    end
  endtask

  initial begin
    rst = 1'b0; FetchValid = 1'b0; PCresult = '0; Instr = '0; IDReady = 1'b0; Flush = 1'b0;
    #3 check_outs();                                    // reset values before any edge
    @(negedge clk); rst = 1'b1;

    // First fetch, 1-cycle latency
    step(1'b1, 8'h00, 32'h2001_0005, 1'b1, 1'b0);
    step(1'b0, 8'h00, 32'h0,         1'b1, 1'b0);

    // Fill to 2, drop third fetch, drain in order
    step(1'b1, 8'h10, 32'hAAAA_0001, 1'b0, 1'b0);
    step(1'b1, 8'h14, 32'hAAAA_0002, 1'b0, 1'b0);
    step(1'b1, 8'h18, 32'hAAAA_0003, 1'b0, 1'b0);
    step(1'b0, 8'h00, 32'h0,         1'b1, 1'b0);
    step(1'b0, 8'h00, 32'h0,         1'b1, 1'b0);
    step(1'b0, 8'h00, 32'h0,         1'b0, 1'b0);

    // Push+pop at Count==1
    step(1'b1, 8'h20, 32'hBBBB_0001, 1'b0, 1'b0);
    step(1'b1, 8'h24, 32'hBBBB_0002, 1'b1, 1'b0);
    step(1'b0, 8'h00, 32'h0,         1'b0, 1'b0);
    step(1'b0, 8'h00, 32'h0,         1'b1, 1'b0);

    // Flush while full with push+pop, then push right after flush
    step(1'b1, 8'h30, 32'hCCCC_0001, 1'b0, 1'b0);
    step(1'b1, 8'h34, 32'hCCCC_0002, 1'b0, 1'b0);
    step(1'b1, 8'h38, 32'hCCCC_0003, 1'b1, 1'b1);
    step(1'b1, 8'h3C, 32'hCCCC_0004, 1'b0, 1'b0);
    step(1'b0, 8'h00, 32'h0,         1'b1, 1'b0);

    // PC+4 wrap
    step(1'b1, 8'hFC, 32'hDDDD_0001, 1'b0, 1'b0);
    step(1'b0, 8'h00, 32'h0,         1'b1, 1'b0);

    // Random traffic
    for (int i = 0; i < 60; i++)
      step(1'($urandom_range(0, 1)), 8'($urandom), $urandom,
           1'($urandom_range(0, 1)), 1'($urandom_range(0, 9) == 0));
    step(1'b0, 8'h00, 32'h0, 1'b0, 1'b1);

    // Asynchronous reset mid-stream with Count==2
    step(1'b1, 8'h40, 32'hEEEE_0001, 1'b0, 1'b0);
    step(1'b1, 8'h44, 32'hEEEE_0002, 1'b0, 1'b0);
    step(1'b1, 8'h48, 32'hEEEE_0003, 1'b0, 1'b0);
    @(negedge clk);
    #2 rst = 1'b0;
    sb.delete(); stall_m = 0;
    #1 check_outs();
    @(posedge clk); #1 check_outs();                   // held in reset through an edge
    @(negedge clk); rst = 1'b1; FetchValid = 1'b0;

`ifdef IFID_STALL_COUNT_EN
    // Long full stall saturates the counter; flush clears it
    step(1'b1, 8'h50, 32'hFFFF_0001, 1'b0, 1'b0);
    step(1'b1, 8'h54, 32'hFFFF_0002, 1'b0, 1'b0);
    for (int i = 0; i < 300; i++) step(1'b1, 8'h58, 32'hFFFF_0003, 1'b0, 1'b0);
    chk("stall_sat", 64'(StallCnt), 64'hFF);
    step(1'b1, 8'h58, 32'hFFFF_0003, 1'b0, 1'b1);
`endif

    step(1'b0, 8'h00, 32'h0, 1'b0, 1'b0);
    step(1'b0, 8'h00, 32'h0, 1'b0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
